debug_uart: RTL and testbench

- Byte-serial UART PHY placed directly downstream of the debug core's byte FIFOs.
- Accepts transmit bytes over a valid/ready handshake and serializes them as 8N1 on uart_txd.
- Deserializes uart_rxd into a single-entry holding register presented over valid/ready.
- Fixed frame format: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity; baud rate set by integer clock divider.

---
 rtl/debug_uart_pkg.sv | 23 ++
 rtl/debug_uart_if.sv | 21 ++
 rtl/debug_uart_rx.sv | 102 ++++++++++
 rtl/debug_uart.sv | 97 +++++++++
 tb/tb_debug_uart.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_uart_pkg.sv
// Shared types and constants for the debug UART PHY: frame geometry and
// the state encodings of the transmit and receive FSMs.
package debug_uart_pkg;

  localparam int UART_DIV_DEFAULT = 434;
  localparam int UART_FRAME_BITS  = 10;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HI
  } rx_state_t;

endpackage

// File: rtl/debug_uart_if.sv
// Byte streams between the debug core FIFOs (master) and the UART PHY (slave).
// Handshake: a byte moves on a rising clk edge where vld && rdy are both high;
// once vld is raised, vld and dat hold until that edge; rdy may change freely.
interface debug_uart_if;
  logic       tx_vld;
  logic [7:0] tx_dat;
  logic       tx_rdy;
  logic       rx_vld;
  logic [7:0] rx_dat;
  logic       rx_rdy;

  modport master (
    output tx_vld, tx_dat, rx_rdy,
    input  tx_rdy, rx_vld, rx_dat
  );

  modport slave (
    input  tx_vld, tx_dat, rx_rdy,
    output tx_rdy, rx_vld, rx_dat
  );
endinterface

// File: rtl/debug_uart_rx.sv
// UART receive half: 2-flop synchronizer, mid-bit sampling FSM, single-entry
// holding register with valid/ready, and one-cycle framing/overrun pulses.
module debug_uart_rx
  import debug_uart_pkg::*;
#(
  parameter int CLK_DIV = UART_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  input  logic       rx_rdy,
  output logic       rx_vld,
  output logic [7:0] rx_dat,
  output logic       err_frm,
  output logic       err_ovr,
  output rx_state_t  state
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);

  logic          s1, s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      s  <= 1'b1;
    end else begin
      s1 <= uart_rxd;
      s  <= s1;
    end
  end

  // cnt is a down-counter; each state acts on the cycle it reaches zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      rx_vld  <= 1'b0;
      rx_dat  <= '0;
      err_frm <= 1'b0;
      err_ovr <= 1'b0;
    end else begin
      err_frm <= 1'b0;
      err_ovr <= 1'b0;
      if (rx_vld && rx_rdy) rx_vld <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!s) begin
            cnt   <= HALF_M1;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (s) state <= RX_IDLE;
          else begin
            cnt     <= BIT_M1;
            bit_idx <= '0;
            state   <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            sh      <= {s, sh[7:1]};
            cnt     <= BIT_M1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (s) begin
            // A consumer taking the old byte this cycle frees the holder.
            if (!rx_vld || rx_rdy) begin
              rx_dat <= sh;
              rx_vld <= 1'b1;
            end else begin
              err_ovr <= 1'b1;
            end
            state <= RX_IDLE;
          end else begin
            err_frm <= 1'b1;
            state   <= RX_WAIT_HI;
          end
        end
        RX_WAIT_HI: begin
          if (s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/debug_uart.sv
// Debug UART PHY: 8N1 serializer for the transmit byte stream plus the
// receive sub-block; both directions run independently.
module debug_uart
  import debug_uart_pkg::*;
#(
  parameter int CLK_DIV = UART_DIV_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  debug_uart_if.slave        bus,
  output logic               uart_txd,
  input  logic               uart_rxd,
  output logic               err_frm,
  output logic               err_ovr,
  output tx_state_t          dbg_tx_state,
  output rx_state_t          dbg_rx_state
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_M1 = CW'(CLK_DIV - 1);

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;

  assign bus.tx_rdy   = (tx_state == TX_IDLE);
  assign dbg_tx_state = tx_state;

  // uart_txd is updated together with each state change so every level
  // lasts exactly CLK_DIV cycles and the line never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      uart_txd <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (bus.tx_vld) begin
            tx_sh    <= bus.tx_dat;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            uart_txd <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt != BIT_M1) tx_cnt <= tx_cnt + 1'b1;
          else begin
            tx_cnt   <= '0;
            uart_txd <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_cnt != BIT_M1) tx_cnt <= tx_cnt + 1'b1;
          else begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              uart_txd <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              uart_txd <= tx_sh[0];
              tx_sh    <= {1'b0, tx_sh[7:1]};
              tx_bit   <= tx_bit + 1'b1;
            end
          end
        end
        TX_STOP: begin
          if (tx_cnt != BIT_M1) tx_cnt <= tx_cnt + 1'b1;
          else begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  debug_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .uart_rxd (uart_rxd),
    .rx_rdy   (bus.rx_rdy),
    .rx_vld   (bus.rx_vld),
    .rx_dat   (bus.rx_dat),
    .err_frm  (err_frm),
    .err_ovr  (err_ovr),
    .state    (dbg_rx_state)
  );

endmodule

// File: tb/tb_debug_uart.sv
// Directed bench for debug_uart at CLK_DIV=8: reset, TX framing and
// back-to-back timing, loopback, overrun, framing error/break and glitch.
module tb_debug_uart;
  import debug_uart_pkg::*;

  localparam int DIV = 8;
  localparam int FRAME = UART_FRAME_BITS * DIV;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  debug_uart_if bus();
  logic      uart_txd, uart_rxd, err_frm, err_ovr;
  logic      loop_en = 1'b0;
  logic      rxd_drv = 1'b1;
  tx_state_t dbg_tx_state;
  rx_state_t dbg_rx_state;

  assign uart_rxd = loop_en ? uart_txd : rxd_drv;

  debug_uart #(.CLK_DIV(DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .uart_txd     (uart_txd),
    .uart_rxd     (uart_rxd),
    .err_frm      (err_frm),
    .err_ovr      (err_ovr),
    .dbg_tx_state (dbg_tx_state),
    .dbg_rx_state (dbg_rx_state)
  );

  // scoreboard
  int n_chk = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int n_frm = 0, n_ovr = 0, n_rise = 0, n_vcyc = 0;
  logic vld_q = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (err_frm) n_frm++;
      if (err_ovr) n_ovr++;
      if (bus.rx_vld) n_vcyc++;
      if (bus.rx_vld && !vld_q) n_rise++;
      if (bus.rx_vld && bus.rx_rdy) got_q.push_back(bus.rx_dat);
    end
    vld_q = bus.rx_vld;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rxd_drv = 1'b0;
    step(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      step(DIV);
    end
    rxd_drv = stop_bit;
    step(DIV);
  endtask

  task automatic check_got(input string tag);
    logic [7:0] e, g;
    check({tag, "_cnt"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check(tag, g, e);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // TX frame check: cycle k (1..) after the handshake edge
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    return f[(k - 1) / DIV];
  endfunction

  int frm0, ovr0, rise0, vcyc0;
  task automatic snap();
    frm0 = n_frm; ovr0 = n_ovr; rise0 = n_rise; vcyc0 = n_vcyc;
  endtask

  initial begin
    bus.tx_vld = 1'b0;
    bus.tx_dat = 8'h00;
    bus.rx_rdy = 1'b0;

    // reset held with line activity
    bus.tx_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rxd_drv = 1'($urandom_range(0, 1));
      step(1);
      check("rst_txd", uart_txd, 1);
      check("rst_tx_rdy", bus.tx_rdy, 1);
      check("rst_rx_vld", bus.rx_vld, 0);
      check("rst_err", {err_frm, err_ovr}, 0);
    end
    check("rst_rx_dat", bus.rx_dat, 0);
    check("rst_rx_state", dbg_rx_state, RX_IDLE);
    bus.tx_vld = 1'b0;
    rxd_drv = 1'b1;
    step(1);
    rst = 1'b1;
    step(4);

    // single frame 0x55
    check("tx55_rdy0", bus.tx_rdy, 1);
    bus.tx_dat = 8'h55;
    bus.tx_vld = 1'b1;
    step(1);
    bus.tx_vld = 1'b0;
    bus.tx_dat = 8'hff;
    for (int k = 1; k <= FRAME + 1; k++) begin
      if (k <= FRAME) begin
        check("tx55_txd", uart_txd, frame_bit(8'h55, k));
        check("tx55_rdy", bus.tx_rdy, 0);
      end else begin
        check("tx55_txd_idle", uart_txd, 1);
        check("tx55_rdy_end", bus.tx_rdy, 1);
      end
      if (k <= FRAME) step(1);
    end
    step(5);

    // back-to-back 0x41, 0x42 with tx_vld held
    bus.tx_dat = 8'h41;
    bus.tx_vld = 1'b1;
    step(1);
    bus.tx_dat = 8'h42;
    for (int k = 1; k <= 2 * FRAME + 1; k++) begin
      if (k <= FRAME) begin
        check("b2b_a_txd", uart_txd, frame_bit(8'h41, k));
        check("b2b_a_rdy", bus.tx_rdy, 0);
      end else if (k == FRAME + 1) begin
        check("b2b_gap_txd", uart_txd, 1);
        check("b2b_gap_rdy", bus.tx_rdy, 1);
      end else begin
        check("b2b_b_txd", uart_txd, frame_bit(8'h42, k - FRAME - 1));
        check("b2b_b_rdy", bus.tx_rdy, 0);
      end
      if (k == FRAME + 2) bus.tx_vld = 1'b0;
      step(1);
    end
    check("b2b_end_rdy", bus.tx_rdy, 1);
    step(5);

    // loopback 0xA3
    snap();
    loop_en = 1'b1;
    bus.rx_rdy = 1'b1;
    exp_q.push_back(8'hA3);
    bus.tx_dat = 8'hA3;
    bus.tx_vld = 1'b1;
    step(1);
    bus.tx_vld = 1'b0;
    step(FRAME + 40);
    check("loop_rise", n_rise - rise0, 1);
    check("loop_vcyc", n_vcyc - vcyc0, 1);
    check("loop_err", {n_frm - frm0, n_ovr - ovr0}, 0);
    check("loop_rx_vld", bus.rx_vld, 0);
    check_got("loop_dat");
    loop_en = 1'b0;

    // overrun: 0x12 held, 0x34 dropped
    snap();
    bus.rx_rdy = 1'b0;
    send_rx(8'h12, 1'b1);
    rxd_drv = 1'b1;
    step(12);
    check("ovr_vld1", bus.rx_vld, 1);
    check("ovr_dat1", bus.rx_dat, 8'h12);
    check("ovr_none_yet", n_ovr - ovr0, 0);
    send_rx(8'h34, 1'b1);
    rxd_drv = 1'b1;
    step(12);
    check("ovr_pulse", n_ovr - ovr0, 1);
    check("ovr_vld2", bus.rx_vld, 1);
    check("ovr_dat2", bus.rx_dat, 8'h12);
    check("ovr_frm", n_frm - frm0, 0);
    exp_q.push_back(8'h12);
    bus.rx_rdy = 1'b1;
    step(1);
    bus.rx_rdy = 1'b0;
    check("ovr_clr", bus.rx_vld, 0);
    check_got("ovr_take");

    // framing error followed by break, then recovery
    snap();
    bus.rx_rdy = 1'b1;
    send_rx(8'h5A, 1'b0);
    rxd_drv = 1'b0;
    step(50);
    check("brk_frm", n_frm - frm0, 1);
    check("brk_state", dbg_rx_state, RX_WAIT_HI);
    check("brk_rise", n_rise - rise0, 0);
    rxd_drv = 1'b1;
    step(10);
    check("brk_idle", dbg_rx_state, RX_IDLE);
    check("brk_frm_once", n_frm - frm0, 1);
    exp_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    rxd_drv = 1'b1;
    step(12);
    check_got("brk_recover");
    check("brk_ovr", n_ovr - ovr0, 0);

    // 2-cycle glitch on idle line
    snap();
    rxd_drv = 1'b0;
    step(2);
    rxd_drv = 1'b1;
    step(30);
    check("glt_rise", n_rise - rise0, 0);
    check("glt_err", {n_frm - frm0, n_ovr - ovr0}, 0);
    check("glt_state", dbg_rx_state, RX_IDLE);

    // asynchronous reset in the middle of a TX frame
    bus.tx_dat = 8'h00;
    bus.tx_vld = 1'b1;
    step(1);
    bus.tx_vld = 1'b0;
    step(20);
    check("mid_txd_low", uart_txd, 0);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_txd", uart_txd, 1);
    check("mid_rst_rdy", bus.tx_rdy, 1);
    check("mid_rst_state", dbg_tx_state, TX_IDLE);
    step(2);
    rst = 1'b1;
    step(DIV * 3);
    check("post_rst_txd", uart_txd, 1);
    check("post_rst_rx", bus.rx_vld, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
